// File: rtl/regbank_dumper_if.sv
// Output stream of the register-bank dumper: one word plus its bank index and end-of-dump flag.
// A word transfers on any rising edge where out_valid and out_ready are both high. Once out_valid
// rises, out_data/out_addr/out_last stay fixed until that transfer. out_ready may change freely.
interface regbank_dumper_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regbank_dumper.sv
// Walks the register bank in address order while holding the datapath, and streams each word out.
// Optional feature macro REGBANK_DUMP_CHECKSUM_EN appends an XOR-of-all-words checksum word.
module regbank_dumper #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg,
  regbank_dumper_if.master  dump
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
`ifdef REGBANK_DUMP_CHECKSUM_EN
  localparam logic [1:0] CSUM  = 2'd3;
  localparam bit         CSUM_ON = 1'b1;
`else
  localparam bit         CSUM_ON = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] index;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_last_q;
`ifdef REGBANK_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      index       <= '0;
      rd_addr     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef REGBANK_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            index   <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
`ifdef REGBANK_DUMP_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        // rd_addr already points at index; the bank answers combinationally this cycle.
        FETCH: begin
          out_data_q  <= rd_data;
          out_addr_q  <= index;
          out_valid_q <= 1'b1;
          out_last_q  <= (index == LAST_IDX) && !CSUM_ON;
`ifdef REGBANK_DUMP_CHECKSUM_EN
          csum_q      <= csum_q ^ rd_data;
`endif
          state       <= SEND;
        end
        SEND: begin
          if (out_valid_q && dump.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (index != LAST_IDX) begin
              index   <= index + 1'b1;
              rd_addr <= index + 1'b1;
              state   <= FETCH;
            end else begin
`ifdef REGBANK_DUMP_CHECKSUM_EN
              out_valid_q <= 1'b1;
              out_data_q  <= csum_q;
              out_addr_q  <= '0;
              out_last_q  <= 1'b1;
              state       <= CSUM;
`else
              state <= IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
`endif
            end
          end
        end
`ifdef REGBANK_DUMP_CHECKSUM_EN
        CSUM: begin
          if (out_valid_q && dump.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state       <= IDLE;
            done        <= 1'b1;
            busy        <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // The datapath stays frozen for exactly the lifetime of a dump.
  assign hold           = busy;
  assign state_dbg      = state;
  assign dump.out_valid = out_valid_q;
  assign dump.out_data  = out_data_q;
  assign dump.out_addr  = out_addr_q;
  assign dump.out_last  = out_last_q;

endmodule

// File: tb/tb_regbank_dumper.sv
// Bench for regbank_dumper: a bank array feeds rd_data, a queue of expected words is built from it.
module tb_regbank_dumper;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int W        = 1 + ADDR_W + DATA_W;
`ifdef REGBANK_DUMP_CHECKSUM_EN
  localparam int CSUM_ON = 1;
`else
  localparam int CSUM_ON = 0;
`endif
  // Cycle (counting the one after the start edge as 1) in which done is high, out_ready held high.
  localparam int DONE_CYC = 2 * NUM_REGS + 1 + CSUM_ON;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              hold;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;
  logic [DATA_W-1:0] bank [NUM_REGS];
  logic [15:0]       pc;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  regbank_dumper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dump ();

  regbank_dumper #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .hold(hold), .busy(busy), .done(done), .state_dbg(state_dbg), .dump(dump)
  );

  always #5 clk = ~clk;

  assign rd_data = bank[rd_addr];

  // Stand-in for the datapath PC: advances every cycle unless held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else if (!hold) pc <= pc + 16'd1;
  end

  task automatic load_linear();
    for (int i = 0; i < NUM_REGS; i++) bank[i] = DATA_W'(i * 3 + 1);
  endtask

  task automatic load_random();
    for (int i = 0; i < NUM_REGS; i++) bank[i] = $urandom;
  endtask

  // Reference: every entry in address order, then the XOR word when the checksum is built in.
  task automatic build_expected();
    logic [DATA_W-1:0] x;
    logic              last;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) begin
      x ^= bank[i];
      last = (i == NUM_REGS - 1) && (CSUM_ON == 0);
      exp_q.push_back({last, ADDR_W'(i), bank[i]});
    end
    if (CSUM_ON != 0) exp_q.push_back({1'b1, ADDR_W'(0), x});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 ready one cycle in three, 2 random.
  task automatic consume_dump(input string name, input int ready_mode, input int restart_at,
                              input int first_cyc, input int done_cyc);
    logic [W-1:0] got, held, exp;
    logic [15:0]  pc0;
    bit seen_done, stalled, restarted;
    int extra, fv;
    seen_done = 0; stalled = 0; restarted = 0; extra = 0; fv = -1; held = '0; pc0 = '0;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      case (ready_mode)
        0:       dump.out_ready = 1'b1;
        1:       dump.out_ready = (cyc % 3 == 0);
        default: dump.out_ready = ($urandom_range(0, 3) != 0);
      endcase
      start = 1'b0;
      if (!restarted && restart_at >= 0 && (NUM_REGS - exp_q.size()) == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      @(negedge clk);
      got = {dump.out_last, dump.out_addr, dump.out_data};
      if (cyc == 1) pc0 = pc;
      if (!seen_done) begin
        if (stalled) begin
          total++;
          if (got !== held || dump.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s stall_stable cyc=%0d got=%h exp=%h", name, cyc, got, held);
          end
        end
        if (dump.out_valid === 1'b1 && fv < 0) fv = cyc;
        if (done === 1'b1) begin
          seen_done = 1;
          total++;
          if (busy !== 1'b0 || hold !== 1'b0 || exp_q.size() != 0 || pc !== pc0) begin
            bad++;
            $display("FAIL %s done_state busy=%b hold=%b left=%0d pc=%0d exp busy=0 hold=0 left=0 pc=%0d",
                     name, busy, hold, exp_q.size(), pc, pc0);
          end
          if (done_cyc > 0) begin
            total++;
            if (cyc != done_cyc) begin
              bad++;
              $display("FAIL %s done_cycle got=%0d exp=%0d", name, cyc, done_cyc);
            end
          end
          if (first_cyc > 0) begin
            total++;
            if (fv != first_cyc) begin
              bad++;
              $display("FAIL %s first_valid_cycle got=%0d exp=%0d", name, fv, first_cyc);
            end
          end
        end else begin
          total++;
          if (busy !== 1'b1 || hold !== 1'b1) begin
            bad++;
            $display("FAIL %s hold_during_dump cyc=%0d busy=%b hold=%b exp=1", name, cyc, busy, hold);
          end
        end
        if (dump.out_valid === 1'b1 && dump.out_ready === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s extra_word got=%h exp=none", name, got);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              bad++;
              $display("FAIL %s word got=%h exp=%h", name, got, exp);
            end
          end
        end
        stalled = (dump.out_valid === 1'b1) && (dump.out_ready === 1'b0);
        held = got;
      end else begin
        extra++;
        total++;
        if (dump.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s after_done valid=%b done=%b busy=%b exp=0", name, dump.out_valid, done, busy);
        end
      end
      @(posedge clk); #2;
      if (seen_done && extra >= 3) break;
    end
    start = 1'b0;
    total++;
    if (!seen_done) begin
      bad++;
      $display("FAIL %s timeout got=no_done exp=done", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dump.out_ready = 1'b0;
    load_linear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({rd_addr, hold, busy, done, dump.out_valid, dump.out_data, dump.out_addr, dump.out_last} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rd_addr, hold, busy, done, dump.out_valid, dump.out_data, dump.out_addr, dump.out_last});
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    total++;
    if (busy !== 1'b0 || hold !== 1'b0 || dump.out_valid !== 1'b0 || pc == 16'd0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b hold=%b valid=%b pc=%0d exp 0 0 0 nonzero",
               busy, hold, dump.out_valid, pc);
    end
  endtask

  task automatic test_full_dump();
    load_linear();
    build_expected();
    pulse_start();
    consume_dump("full_dump", 0, -1, 2, DONE_CYC);
  endtask

  task automatic test_backpressure();
    load_linear();
    build_expected();
    pulse_start();
    consume_dump("backpressure", 1, -1, 2, -1);
  endtask

  task automatic test_restart_ignored();
    load_linear();
    build_expected();
    pulse_start();
    consume_dump("restart_ignored", 0, 10, 2, DONE_CYC);
  endtask

  task automatic test_reset_mid_dump();
    bit hit;
    hit = 0;
    load_linear();
    dump.out_ready = 1'b1;
    pulse_start();
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (dump.out_valid === 1'b1 && dump.out_addr === ADDR_W'(7)) begin
        #1 rst_n = 1'b0;
        #1;
        hit = 1;
        total++;
        if ({rd_addr, hold, busy, done, dump.out_valid, dump.out_data, dump.out_addr, dump.out_last} !== '0) begin
          bad++;
          $display("FAIL async_reset_outputs got=%h exp=0",
                   {rd_addr, hold, busy, done, dump.out_valid, dump.out_data, dump.out_addr, dump.out_last});
        end
        break;
      end
      @(posedge clk); #2;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reset_mid_dump_reach got=no_word7 exp=word7");
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    build_expected();
    pulse_start();
    consume_dump("after_reset", 0, -1, 2, DONE_CYC);
  endtask

  task automatic test_corner_values();
    load_random();
    bank[5]  = 32'hFFFF_FFFF;
    bank[31] = 32'h8000_0001;
    build_expected();
    pulse_start();
    consume_dump("corner_values", 2, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      load_random();
      build_expected();
      pulse_start();
      consume_dump("random", 2, -1, -1, -1);
    end
  endtask

  task automatic test_back_to_back();
    load_linear();
    dump.out_ready = 1'b1;
    pulse_start();
    for (int cyc = 1; cyc < DONE_CYC; cyc++) begin
      @(posedge clk); #2;
    end
    start = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_cycle done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || dump.out_valid !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart busy=%b valid=%b done=%b exp 1 0 0", busy, dump.out_valid, done);
    end
    @(posedge clk); #2;
    build_expected();
    consume_dump("back_to_back", 0, -1, 1, DONE_CYC - 1);
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_dump();
    test_corner_values();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
